// File: rtl/m2p_pipe_arbiter.sv
// m2p_pipe_arbiter: round-robin, message-granular sharing of one indication pipe
// between NREQ method-to-pipe adapters, with a one-entry registered output stage.
module m2p_pipe_arbiter #(
    parameter int  NREQ   = 4,
    parameter int  DWIDTH = 128,
    parameter int  LWIDTH = 16,
    localparam int GW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          in_req,
    input  logic [NREQ-1:0]          in_enq__ENA,
    input  logic [NREQ*DWIDTH-1:0]   in_enq_v,
    input  logic [NREQ*LWIDTH-1:0]   in_enq_length,
    output logic [NREQ-1:0]          in_enq__RDY,
    output logic                     pipe_enq__ENA,
    output logic [DWIDTH-1:0]        pipe_enq_v,
    output logic [LWIDTH-1:0]        pipe_enq_length,
    input  logic                     pipe_enq__RDY,
    output logic                     busy,
    output logic [GW-1:0]            grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    localparam logic [LWIDTH-1:0] LEN_ONE  = LWIDTH'(1'b1);
    localparam logic [LWIDTH-1:0] LEN_ZERO = {LWIDTH{1'b0}};

    state_t              state_r;
    logic [GW-1:0]       rr_ptr_r;
    logic [GW-1:0]       grant_id_r;
    logic [LWIDTH-1:0]   beats_left_r;
    logic                out_valid_r;
    logic [DWIDTH-1:0]   out_v_r;
    logic [LWIDTH-1:0]   out_len_r;

    logic                pipe_fire_s;
    logic                accept_s;
    logic                lane_open_s;
    logic                beat_s;
    logic                found_s;
    logic [NREQ-1:0]     rdy_s;
    logic [DWIDTH-1:0]   sel_v_s;
    logic [LWIDTH-1:0]   sel_len_s;
    logic [LWIDTH-1:0]   first_len_s;
    logic [GW-1:0]       next_g_s;

    // Lane index k positions after ptr, wrapping modulo NREQ (sum is below 2*NREQ).
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] ptr, input int k);
        int sum;
        sum = int'(ptr) + k;
        return (sum >= NREQ) ? GW'(sum - NREQ) : GW'(sum);
    endfunction

    // Output-stage handshake: a held beat leaving this cycle frees the slot for a refill.
    always_comb begin
        pipe_fire_s = out_valid_r & pipe_enq__RDY;
        accept_s    = ~out_valid_r | pipe_fire_s;
        lane_open_s = accept_s & ((state_r == ST_GRANT) | (state_r == ST_BURST));
        rdy_s       = lane_open_s ? (NREQ'(1'b1) << grant_id_r) : {NREQ{1'b0}};
        beat_s      = |(in_enq__ENA & rdy_s);
    end

    // Select the granted lane's beat and length; a zero length means a single beat.
    always_comb begin
        sel_v_s   = {DWIDTH{1'b0}};
        sel_len_s = LEN_ZERO;
        for (int i = 0; i < NREQ; i++) begin
            sel_v_s   = (grant_id_r == GW'(i)) ? in_enq_v[i*DWIDTH +: DWIDTH] : sel_v_s;
            sel_len_s = (grant_id_r == GW'(i)) ? in_enq_length[i*LWIDTH +: LWIDTH] : sel_len_s;
        end
        first_len_s = (sel_len_s == LEN_ZERO) ? LEN_ONE : sel_len_s;
    end

    // Round-robin search for the first requester after the last served one.
    always_comb begin
        found_s  = 1'b0;
        next_g_s = {GW{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            next_g_s = (!found_s && in_req[rr_index(rr_ptr_r, k)]) ? rr_index(rr_ptr_r, k) : next_g_s;
            found_s  = found_s | in_req[rr_index(rr_ptr_r, k)];
        end
    end

    // Arbitration FSM and output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= GW'(NREQ - 1);
            grant_id_r   <= {GW{1'b0}};
            beats_left_r <= LEN_ZERO;
            out_valid_r  <= 1'b0;
            out_v_r      <= {DWIDTH{1'b0}};
            out_len_r    <= LEN_ZERO;
        end else begin
            // Length is only meaningful on the first beat; later beats keep the latched value.
            if (beat_s) begin
                out_valid_r <= 1'b1;
                out_v_r     <= sel_v_s;
                if (state_r == ST_GRANT) begin
                    out_len_r <= sel_len_s;
                end
            end else if (pipe_fire_s) begin
                out_valid_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_id_r <= next_g_s;
                        state_r    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (beat_s) begin
                        if (first_len_s == LEN_ONE) begin
                            state_r  <= ST_IDLE;
                            rr_ptr_r <= grant_id_r;
                        end else begin
                            beats_left_r <= first_len_s - LEN_ONE;
                            state_r      <= ST_BURST;
                        end
                    end else if (!in_req[grant_id_r]) begin
                        state_r  <= ST_IDLE;
                        rr_ptr_r <= grant_id_r;
                    end
                end
                ST_BURST: begin
                    if (beat_s) begin
                        beats_left_r <= beats_left_r - LEN_ONE;
                        if (beats_left_r == LEN_ONE) begin
                            state_r  <= ST_IDLE;
                            rr_ptr_r <= grant_id_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_enq__RDY     = rdy_s;
    assign pipe_enq__ENA   = pipe_fire_s;
    assign pipe_enq_v      = out_v_r;
    assign pipe_enq_length = out_len_r;
    assign grant_id        = grant_id_r;
    assign busy            = (state_r != ST_IDLE) | out_valid_r;

endmodule

// File: tb/tb_m2p_pipe_arbiter.sv
// Scoreboard bench for m2p_pipe_arbiter: per-lane message sources, a beat queue filled
// on acceptance, and an expected message-order model checked on the pipe side.
module tb_m2p_pipe_arbiter;
    localparam int NREQ   = 4;
    localparam int DWIDTH = 128;
    localparam int LWIDTH = 16;
    localparam int MAXM   = 8;

    typedef struct { int lane; int slot; } exp_msg_t;
    typedef struct { logic [DWIDTH-1:0] v; logic [LWIDTH-1:0] len; } beat_t;

    logic                   clk_s = 1'b0;
    logic                   rst_s;
    logic [NREQ-1:0]        req_s;
    logic [NREQ-1:0]        ena_s;
    logic [NREQ*DWIDTH-1:0] v_bus_s;
    logic [NREQ*LWIDTH-1:0] len_bus_s;
    logic [NREQ-1:0]        rdy_s;
    logic                   pipe_ena_s;
    logic [DWIDTH-1:0]      pipe_v_s;
    logic [LWIDTH-1:0]      pipe_len_s;
    logic                   pipe_rdy_s;
    logic                   busy_s;
    logic [1:0]             grant_id_s;

    m2p_pipe_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .LWIDTH(LWIDTH)) dut (
        .CLK(clk_s), .RST(rst_s),
        .in_req(req_s), .in_enq__ENA(ena_s), .in_enq_v(v_bus_s), .in_enq_length(len_bus_s),
        .in_enq__RDY(rdy_s),
        .pipe_enq__ENA(pipe_ena_s), .pipe_enq_v(pipe_v_s), .pipe_enq_length(pipe_len_s),
        .pipe_enq__RDY(pipe_rdy_s),
        .busy(busy_s), .grant_id(grant_id_s)
    );

    always #5 clk_s = ~clk_s;

    int vectors = 0;
    int miscompares = 0;

    // sources
    int               m_beats [NREQ][MAXM];
    logic [LWIDTH-1:0] m_len  [NREQ][MAXM];
    int               m_cnt   [NREQ];
    int               m_head  [NREQ];
    int               m_beat  [NREQ];
    int               exp_next[NREQ];
    logic [NREQ-1:0]  force_req;
    logic             rst_cmd;
    logic             pipe_rdy_cmd;

    // scoreboard / order model
    beat_t     beat_q[$];
    exp_msg_t  exp_q[$];
    int        cur_lane, cur_slot, cur_left, cur_beats;
    int        pipe_beats;

    // pre-posedge samples
    logic [NREQ-1:0]   s_rdy;
    logic              s_pipe_ena, s_busy;
    logic [DWIDTH-1:0] s_pipe_v;
    logic [LWIDTH-1:0] s_pipe_len;
    logic [1:0]        s_grant;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DWIDTH-1:0] beat_data(input int lane, input int slot, input int beat);
        return {80'h0, 16'(lane), 16'(slot), 16'(beat)};
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++)
            if (m_head[i] < m_cnt[i] || force_req[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_msg(input int lane, input int len);
        m_len[lane][m_cnt[lane]]   = 16'(len);
        m_beats[lane][m_cnt[lane]] = (len == 0) ? 1 : len;
        m_cnt[lane]++;
    endtask

    task automatic expect_msg(input int lane);
        exp_q.push_back('{lane: lane, slot: exp_next[lane]});
        exp_next[lane]++;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NREQ; i++) begin
            m_cnt[i] = 0; m_head[i] = 0; m_beat[i] = 0; exp_next[i] = 0;
        end
        force_req = '0;
        beat_q.delete();
        exp_q.delete();
        cur_left = 0; cur_lane = -1; cur_slot = -1; cur_beats = 0;
    endtask

    task automatic monitor_pipe();
        beat_t bt;
        exp_msg_t e;
        if (beat_q.size() == 0) begin
            check_val("pipe_extra_beat", 128'(1), 128'(0));
        end else begin
            bt = beat_q.pop_front();
            check_val("pipe_v", pipe_v_s, bt.v);
            check_val("pipe_len", 128'(pipe_len_s), 128'(bt.len));
        end
        if (cur_left == 0) begin
            if (exp_q.size() == 0) begin
                check_val("order_extra_msg", 128'(1), 128'(0));
            end else begin
                e = exp_q.pop_front();
                cur_lane = e.lane; cur_slot = e.slot;
                cur_beats = m_beats[e.lane][e.slot];
                cur_left = cur_beats;
            end
        end
        check_val("beat_lane", 128'(pipe_v_s[47:32]), 128'(16'(cur_lane)));
        check_val("beat_slot", 128'(pipe_v_s[31:16]), 128'(16'(cur_slot)));
        check_val("beat_idx", 128'(pipe_v_s[15:0]), 128'(16'(cur_beats - cur_left)));
        if (cur_left > 0) cur_left--;
        pipe_beats++;
    endtask

    task automatic step();
        @(negedge clk_s);
        rst_s = rst_cmd;
        pipe_rdy_s = pipe_rdy_cmd;
        for (int i = 0; i < NREQ; i++) begin
            if (m_head[i] < m_cnt[i]) begin
                req_s[i] = 1'b1;
                v_bus_s[i*DWIDTH +: DWIDTH] = beat_data(i, m_head[i], m_beat[i]);
                len_bus_s[i*LWIDTH +: LWIDTH] = (m_beat[i] == 0) ? m_len[i][m_head[i]] : 16'hDEAD;
            end else begin
                req_s[i] = force_req[i];
                v_bus_s[i*DWIDTH +: DWIDTH] = '0;
                len_bus_s[i*LWIDTH +: LWIDTH] = '0;
            end
        end
        ena_s = '0;
        #1;
        for (int i = 0; i < NREQ; i++)
            ena_s[i] = (m_head[i] < m_cnt[i]) && rdy_s[i] && !rst_cmd;
        #2;
        s_rdy = rdy_s; s_pipe_ena = pipe_ena_s; s_busy = busy_s;
        s_pipe_v = pipe_v_s; s_pipe_len = pipe_len_s; s_grant = grant_id_s;
        if (!rst_cmd) begin
            check_val("rdy_onehot0", 128'($onehot0(rdy_s)), 128'(1));
            if (pipe_ena_s) monitor_pipe();
            for (int i = 0; i < NREQ; i++) begin
                if (ena_s[i] && rdy_s[i]) begin
                    beat_q.push_back('{v: beat_data(i, m_head[i], m_beat[i]), len: m_len[i][m_head[i]]});
                    m_beat[i]++;
                    if (m_beat[i] == m_beats[i][m_head[i]]) begin
                        m_beat[i] = 0;
                        m_head[i]++;
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst_cmd = 1'b1;
        step();
        rst_cmd = 1'b0;
        clear_sources();
        step();
        check_val("rst_in_rdy", 128'(s_rdy), 128'(0));
        check_val("rst_pipe_ena", 128'(s_pipe_ena), 128'(0));
        check_val("rst_pipe_v", s_pipe_v, 128'(0));
        check_val("rst_pipe_len", 128'(s_pipe_len), 128'(0));
        check_val("rst_busy", 128'(s_busy), 128'(0));
        check_val("rst_grant_id", 128'(s_grant), 128'(0));
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        int n;
        n = 0;
        step(); n++;
        while ((pending() || beat_q.size() != 0 || s_busy) && n < max_cycles) begin
            step(); n++;
        end
        check_val({tag, "_drained"}, 128'(n < max_cycles), 128'(1));
        check_val({tag, "_msgs_left"}, 128'(exp_q.size() + cur_left), 128'(0));
    endtask

    initial begin
        int n;
        logic [DWIDTH-1:0] held_v;
        rst_cmd = 1'b1; pipe_rdy_cmd = 1'b1; pipe_beats = 0;
        rst_s = 1'b1; pipe_rdy_s = 1'b1; req_s = '0; ena_s = '0; v_bus_s = '0; len_bus_s = '0;
        clear_sources();
        do_reset();

        // 1: single one-beat message, latency
        add_msg(0, 1); expect_msg(0);
        step();
        check_val("t1_rdy_c1", 128'(s_rdy), 128'(0));
        step();
        check_val("t1_rdy_c2", 128'(s_rdy), 128'(4'b0001));
        step();
        check_val("t1_pipe_ena_c3", 128'(s_pipe_ena), 128'(1));
        check_val("t1_pipe_len_c3", 128'(s_pipe_len), 128'(1));
        check_val("t1_busy_c3", 128'(s_busy), 128'(1));
        step();
        check_val("t1_busy_after", 128'(s_busy), 128'(0));
        check_val("t1_pipe_ena_after", 128'(s_pipe_ena), 128'(0));

        // 2: all four requesting, two one-beat messages each
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int l = 0; l < NREQ; l++) begin
                add_msg(l, 1); expect_msg(l);
            end
        run_until_idle("t2", 200);

        // 3: len=3 from lane 2 while lane 0 waits
        add_msg(1, 1); expect_msg(1);
        run_until_idle("t3a", 50);
        add_msg(2, 3); add_msg(0, 1);
        expect_msg(2); expect_msg(0);
        run_until_idle("t3b", 50);

        // 4: pipe stall mid-burst
        do_reset();
        add_msg(3, 6); expect_msg(3);
        pipe_beats = 0; n = 0;
        while (pipe_beats < 2 && n < 30) begin step(); n++; end
        check_val("t4_reach_stall", 128'(pipe_beats), 128'(2));
        pipe_rdy_cmd = 1'b0;
        step();
        held_v = s_pipe_v;
        check_val("t4_stall_rdy", 128'(s_rdy), 128'(0));
        check_val("t4_stall_ena", 128'(s_pipe_ena), 128'(0));
        for (int c = 0; c < 4; c++) begin
            step();
            check_val("t4_stall_rdy", 128'(s_rdy), 128'(0));
            check_val("t4_stall_ena", 128'(s_pipe_ena), 128'(0));
            check_val("t4_stall_v", s_pipe_v, held_v);
        end
        pipe_rdy_cmd = 1'b1;
        run_until_idle("t4", 50);
        check_val("t4_beats", 128'(pipe_beats), 128'(6));

        // 5: withdrawn request, then a zero-length message
        do_reset();
        force_req[1] = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(s_grant == 2'd1 && s_rdy == 4'b0010) && n < 20);
        check_val("t5_grant1", 128'(s_rdy), 128'(4'b0010));
        force_req[1] = 1'b0;
        add_msg(2, 0); expect_msg(2);
        step();
        step();
        check_val("t5_withdraw_idle", 128'(s_rdy), 128'(0));
        step();
        check_val("t5_grant2", 128'(s_grant), 128'(2));
        check_val("t5_rdy2", 128'(s_rdy), 128'(4'b0100));
        pipe_beats = 0;
        run_until_idle("t5", 50);
        check_val("t5_beats", 128'(pipe_beats), 128'(1));

        // 6: reset in the middle of a burst
        do_reset();
        add_msg(1, 4); expect_msg(1);
        pipe_beats = 0; n = 0;
        while (pipe_beats < 2 && n < 30) begin step(); n++; end
        check_val("t6_mid_burst", 128'(pipe_beats), 128'(2));
        do_reset();
        add_msg(2, 1); add_msg(0, 1);
        expect_msg(0); expect_msg(2);
        run_until_idle("t6", 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
